// File: rtl/uart_pkg.sv
// Shared parity constants, FSM encodings and elaboration-time helpers for the UART.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input longint value);
    longint reach;
    int     width;
    reach = 64'sd2;
    width = 1;
    while (reach < value) begin
      reach = reach * 64'sd2;
      width = width + 1;
    end
    return width;
  endfunction

  function automatic int calc_div(input longint clk_hz, input longint baud, input longint os);
    return int'((clk_hz + (baud * os) / 64'sd2) / (baud * os));
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    if (mode == PARITY_ODD) begin
      return ~^data;
    end else begin
      return ^data;
    end
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: clock-timed transmitter and oversampling receiver with a
// one-entry holding register reporting parity, framing and overrun errors.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 16,
  parameter int DataBits     = 8,
  parameter int ParityMode   = 0,
  parameter int StopBits     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DataBits-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                txd,
  input  logic                rxd,
  output logic [DataBits-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                rx_parity_err,
  output logic                rx_frame_err,
  output logic                rx_overrun,
  output logic                rx_busy
);

  localparam int DIV    = calc_div(ClkFrequency, Baud, Oversampling);
  localparam int BITCLK = DIV * Oversampling;
  localparam int TX_TW  = clog2(StopBits * BITCLK);
  localparam int OS_W   = clog2(Oversampling);
  localparam int BIT_W  = clog2(DataBits);

  localparam logic [TX_TW-1:0] TX_BIT_LAST  = TX_TW'(BITCLK - 1);
  localparam logic [TX_TW-1:0] TX_STOP_LAST = TX_TW'(StopBits * BITCLK - 1);
  localparam logic [BIT_W-1:0] LAST_BIT     = BIT_W'(DataBits - 1);
  localparam logic [OS_W-1:0]  OS_LAST      = OS_W'(Oversampling - 1);
  localparam logic [OS_W-1:0]  OS_HALF_LAST = OS_W'(Oversampling / 2 - 1);
  localparam logic             HAS_PARITY   = (ParityMode != PARITY_NONE);

  if (Baud < 1 || Oversampling < 8 || ((Oversampling & (Oversampling - 1)) != 0) ||
      ClkFrequency / (Baud * Oversampling) < 1 || DataBits < 5 || DataBits > 8 ||
      ParityMode < 0 || ParityMode > 2 || StopBits < 1 || StopBits > 2) begin : g_bad_param
    $error("uart_transceiver: parameter out of range");
  end

  // ---------------- transmitter ----------------
  tx_state_t           tx_state, tx_state_next;
  logic [TX_TW-1:0]    tx_timer, tx_timer_next;
  logic [BIT_W-1:0]    tx_bit, tx_bit_next;
  logic [DataBits-1:0] tx_shift, tx_shift_next;
  logic                tx_par, tx_par_next;
  logic                txd_next, tx_ready_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      txd      <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_timer <= tx_timer_next;
      tx_bit   <= tx_bit_next;
      tx_shift <= tx_shift_next;
      tx_par   <= tx_par_next;
      txd      <= txd_next;
      tx_ready <= tx_ready_next;
    end
  end

  // Bit timing runs on its own clock counter so START begins exactly one clock after accept.
  always_comb begin
    tx_state_next = tx_state;
    tx_timer_next = tx_timer + TX_TW'(1);
    tx_bit_next   = tx_bit;
    tx_shift_next = tx_shift;
    tx_par_next   = tx_par;
    case (tx_state)
      TX_IDLE: begin
        tx_timer_next = '0;
        if (tx_valid && tx_ready) begin
          tx_state_next = TX_START;
          tx_bit_next   = '0;
          tx_shift_next = tx_data;
          tx_par_next   = parity_bit(8'(tx_data), ParityMode);
        end else begin
          tx_state_next = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_timer == TX_BIT_LAST) begin
          tx_state_next = TX_DATA;
          tx_timer_next = '0;
        end else begin
          tx_state_next = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_timer == TX_BIT_LAST) begin
          tx_timer_next = '0;
          tx_shift_next = {1'b0, tx_shift[DataBits-1:1]};
          if (tx_bit == LAST_BIT) begin
            tx_state_next = HAS_PARITY ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_next = tx_bit + BIT_W'(1);
          end
        end else begin
          tx_state_next = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tx_timer == TX_BIT_LAST) begin
          tx_state_next = TX_STOP;
          tx_timer_next = '0;
        end else begin
          tx_state_next = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tx_timer == TX_STOP_LAST) begin
          tx_state_next = TX_IDLE;
          tx_timer_next = '0;
        end else begin
          tx_state_next = TX_STOP;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_timer_next = '0;
      end
    endcase
  end

  always_comb begin
    tx_ready_next = (tx_state_next == TX_IDLE);
    case (tx_state_next)
      TX_START:  txd_next = 1'b0;
      TX_DATA:   txd_next = tx_shift_next[0];
      TX_PARITY: txd_next = tx_par_next;
      default:   txd_next = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0]          rx_sync;
  logic                rxs;
  logic                os_tick;
  rx_state_t           rx_state, rx_state_next;
  logic [OS_W-1:0]     rx_os, rx_os_next;
  logic [BIT_W-1:0]    rx_bit, rx_bit_next;
  logic [DataBits-1:0] rx_shift, rx_shift_next;
  logic                rx_par, rx_par_next;
  logic                frame_done, rx_load, rx_busy_next, rx_overrun_next;
  logic                rx_parity_err_next;

  assign rxs = rx_sync[1];

  uart_baud_tick #(.DIV(DIV)) u_os_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (os_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_os    <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par   <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_state <= rx_state_next;
      rx_os    <= rx_os_next;
      rx_bit   <= rx_bit_next;
      rx_shift <= rx_shift_next;
      rx_par   <= rx_par_next;
    end
  end

  // Sample counter wraps at Oversampling, so each later sample lands one bit after the last.
  always_comb begin
    rx_state_next = rx_state;
    rx_os_next    = rx_os;
    rx_bit_next   = rx_bit;
    rx_shift_next = rx_shift;
    rx_par_next   = rx_par;
    frame_done    = 1'b0;
    if (os_tick && rx_state != RX_IDLE) begin
      rx_os_next = rx_os + OS_W'(1);
    end else begin
      rx_os_next = rx_os;
    end
    case (rx_state)
      RX_IDLE: begin
        if (os_tick && !rxs) begin
          rx_state_next = RX_START;
          rx_os_next    = '0;
        end else begin
          rx_state_next = RX_IDLE;
        end
      end
      RX_START: begin
        if (os_tick && rx_os == OS_HALF_LAST) begin
          rx_os_next    = '0;
          rx_bit_next   = '0;
          rx_state_next = rxs ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_next = RX_START;
        end
      end
      RX_DATA: begin
        if (os_tick && rx_os == OS_LAST) begin
          rx_shift_next = {rxs, rx_shift[DataBits-1:1]};
          if (rx_bit == LAST_BIT) begin
            rx_state_next = HAS_PARITY ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_next = rx_bit + BIT_W'(1);
          end
        end else begin
          rx_state_next = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (os_tick && rx_os == OS_LAST) begin
          rx_par_next   = rxs;
          rx_state_next = RX_STOP;
        end else begin
          rx_state_next = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (os_tick && rx_os == OS_LAST) begin
          frame_done    = 1'b1;
          rx_state_next = rxs ? RX_IDLE : RX_WAIT_HIGH;
        end else begin
          rx_state_next = RX_STOP;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxs) begin
          rx_state_next = RX_IDLE;
        end else begin
          rx_state_next = RX_WAIT_HIGH;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_busy_next       = (rx_state_next != RX_IDLE);
    rx_load            = frame_done && (!rx_valid || rx_ready);
    rx_overrun_next    = frame_done && rx_valid && !rx_ready;
    rx_parity_err_next = HAS_PARITY && (parity_bit(8'(rx_shift), ParityMode) != rx_par);
  end

  // Holding register: a full, unacknowledged register keeps its frame and drops the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_overrun <= rx_overrun_next;
      rx_busy    <= rx_busy_next;
      if (rx_load) begin
        rx_data       <= rx_shift;
        rx_parity_err <= rx_parity_err_next;
        rx_frame_err  <= !rxs;
        rx_valid      <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end else begin
        rx_valid <= rx_valid;
      end
    end
  end

endmodule
